updown_sweep_ctrl: RTL
======================

UPDOWN_SWEEP_CTRL -- requirements
Module: updown_sweep_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 4, counter/limit width.
- DWELL, 3, hold cycles at each end point (>=1).

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin sweeping (sampled in IDLE only).
- stop  in  1  abort sweeping, return to IDLE.
- lo_lim  in  WIDTH  lower sweep limit.
- hi_lim  in  WIDTH  upper sweep limit.
- cnt_in  in  WIDTH  current value fed back from the controlled up/down counter.
- cnt_en  out  1  count enable to the counter.
- UpDown  out  1  direction to the counter: 1=up, 0=down.
- load  out  1  one-cycle load strobe to the counter.
- load_val  out  WIDTH  value to load.
- busy  out  1  high whenever state != IDLE.
- sweep_done  out  1  one-cycle pulse per completed up+down sweep.
- cfg_err  out  1  one-cycle pulse on a rejected start.
- sweeps  out  8  completed sweep count.

REQ-003 Clock and reset SHALL be exactly as decided: one clock clk; reset is synchronous and active-high.

Function
REQ-004 The FSM SHALL have the states IDLE, LOAD, UP, DWELL_HI, DOWN and DWELL_LO, held in a single state register.

REQ-005 In IDLE, start=1 with lo_lim<hi_lim and stop=0 SHALL latch lo_lim/hi_lim into internal registers and go to LOAD next cycle.

REQ-006 In IDLE, start=1 with lo_lim>=hi_lim SHALL pulse cfg_err for one cycle and remain in IDLE.

REQ-007 In IDLE, start and stop asserted together SHALL leave the block in IDLE with no cfg_err.

REQ-008 LOAD SHALL assert load=1 and load_val=latched lo, last exactly one cycle, then go to UP.

REQ-009 load_val SHALL equal latched lo in every state; load SHALL be 0 outside LOAD.

REQ-010 UP SHALL drive UpDown=1 and cnt_en=(cnt_in<latched hi).

REQ-011 UP SHALL go to DWELL_HI in the cycle after cnt_in>=latched hi is observed.

REQ-012 DOWN SHALL drive UpDown=0 and cnt_en=(cnt_in>latched lo).

REQ-013 DOWN SHALL go to DWELL_LO in the cycle after cnt_in<=latched lo is observed.

REQ-014 DWELL_HI and DWELL_LO SHALL each last exactly DWELL cycles with cnt_en=0, timed by an internal dwell counter cleared on entry.

REQ-015 UpDown SHALL be 0 in DOWN and DWELL_LO, and 1 in all other states.

REQ-016 Leaving DWELL_LO SHALL pulse sweep_done for one cycle, increment sweeps (saturating at 255), and go to UP.

REQ-017 Sweeping SHALL be continuous until stop is asserted.

REQ-018 stop=1 in any non-IDLE state SHALL force IDLE on the next edge with cnt_en=0, even if that cycle would have completed a sweep.
- The aborted partial sweep SHALL produce no sweep_done pulse and no sweeps increment.

REQ-019 start while busy SHALL be ignored.

REQ-020 Changes to lo_lim/hi_lim while busy SHALL have no effect until the next accepted start.

REQ-021 sweeps SHALL be preserved across stop and cleared only by reset.

Reset
REQ-022 reset=1 SHALL override start/stop and place the block at the next edge in:
- state IDLE.
- cnt_en=0, load=0, busy=0.
- sweep_done=0, cfg_err=0.
- UpDown=1.
- sweeps=0.
- latched limits = 0.
- dwell counter = 0.

REQ-023 reset asserted mid-sweep SHALL abort without any sweep_done pulse.

Verification
REQ-024 The bench (WIDTH=4, DWELL=3, behavioural up/down counter with load) SHALL cover the following scenarios:
- Reset held 2 cycles -> IDLE, busy=0, cnt_en=0, UpDown=1, sweeps=0.
- lo=2, hi=5, start pulse at cycle N -> load=1, load_val=2 at N+1; counter 2->5 with cnt_en=1 for 3 cycles; 3 dwell cycles; 5->2 with UpDown=0; 3 dwell cycles; sweep_done pulse, sweeps=1; repeats.
- start with lo=5, hi=5 -> cfg_err single pulse, busy stays 0, load never asserted.
- stop during DOWN at count 4 -> next cycle IDLE, cnt_en=0, busy=0, no sweep_done, sweeps unchanged; start+stop together in IDLE -> stays IDLE.
- hi_lim changed 5->9 during UP -> counter still peaks at 5; new limits take effect only after stop and restart.
- lo=0, hi=1, run 260 sweeps -> sweeps saturates at 255; reset asserted mid-UP -> IDLE, sweeps=0 next cycle.

Source files
------------

// File: rtl/updown_sweep_ctrl.sv
// Up/down sweep controller: drives an external loadable up/down counter
// between latched limits, dwelling at each end point, until stopped.
module updown_sweep_ctrl #(
   parameter int WIDTH = 4,
   parameter int DWELL = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] lo_lim,
   input  logic [WIDTH-1:0] hi_lim,
   input  logic [WIDTH-1:0] cnt_in,
   output logic             cnt_en,
   output logic             UpDown,
   output logic             load,
   output logic [WIDTH-1:0] load_val,
   output logic             busy,
   output logic             sweep_done,
   output logic             cfg_err,
   output logic [7:0]       sweeps
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD     = 3'd1;
   localparam logic [2:0] S_UP       = 3'd2;
   localparam logic [2:0] S_DWELL_HI = 3'd3;
   localparam logic [2:0] S_DOWN     = 3'd4;
   localparam logic [2:0] S_DWELL_LO = 3'd5;

   localparam int DW = $clog2(DWELL + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [DW-1:0]    dwell_q, dwell_d;
   logic [7:0]       sweeps_q, sweeps_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   always_comb begin
      state_d  = state_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      dwell_d  = '0;
      sweeps_d = sweeps_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               if (lo_lim < hi_lim) begin
                  lo_d    = lo_lim;
                  hi_d    = hi_lim;
                  state_d = S_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LOAD: state_d = S_UP;
         S_UP: begin
            if (cnt_in >= hi_q) state_d = S_DWELL_HI;
         end
         S_DWELL_HI: begin
            if (dwell_q == DWELL_LAST) state_d = S_DOWN;
            else dwell_d = dwell_q + 1'b1;
         end
         S_DOWN: begin
            if (cnt_in <= lo_q) state_d = S_DWELL_LO;
         end
         S_DWELL_LO: begin
            if (dwell_q == DWELL_LAST) begin
               state_d = S_UP;
               done_d  = 1'b1;
               if (sweeps_q != 8'hFF) sweeps_d = sweeps_q + 8'd1;
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // stop wins over a sweep that would complete this cycle
      if (stop && state_q != S_IDLE) begin
         state_d  = S_IDLE;
         done_d   = 1'b0;
         sweeps_d = sweeps_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         lo_q     <= '0;
         hi_q     <= '0;
         dwell_q  <= '0;
         sweeps_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         dwell_q  <= dwell_d;
         sweeps_q <= sweeps_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign load       = (state_q == S_LOAD);
   assign load_val   = lo_q;
   assign busy       = (state_q != S_IDLE);
   assign UpDown     = !(state_q == S_DOWN || state_q == S_DWELL_LO);
   assign cnt_en     = (state_q == S_UP   && cnt_in < hi_q) ||
                       (state_q == S_DOWN && cnt_in > lo_q);
   assign sweep_done = done_q;
   assign cfg_err    = err_q;
   assign sweeps     = sweeps_q;

endmodule
